// File: rtl/accelerator_read_keys_transmitter_pkg.sv
// Shared definitions for the read-head transmitters (keys, modes, strengths).
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package accelerator_read_keys_transmitter_pkg;

    // Defaults shared by every read-head transmitter
    localparam int DATA_SIZE_DEF    = 64;
    localparam int CONTROL_SIZE_DEF = 64;
    localparam int R_MAX_DEF        = 4;   // read heads (rows), power of two
    localparam int W_MAX_DEF        = 16;  // words per row, power of two

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } tx_state_t;

    // Buffer address width; the address is {i, k} because both maxima are powers of two
    function automatic int addr_width(input int r_max, input int w_max);
        return $clog2(r_max * w_max);
    endfunction

endpackage

// File: rtl/accelerator_read_keys_transmitter_buffer.sv
// Key buffer: R_MAX*W_MAX words, registered write port, asynchronous read port.
// Latency: write visible to the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module accelerator_read_keys_transmitter_buffer #(
    parameter int DATA_SIZE = 64,
    parameter int AW        = 6
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    // Deliberately not reset: contents persist across streams and resets
    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/accelerator_read_keys_transmitter.sv
// Streams a host-loaded R x W read-key matrix onto K_IN, one word per cycle, row-start flagged.
// Latency: first word registered one cycle after START; READY pulses one cycle after the last word.
// Backpressure: none; the consumer must take every word; START and loads are ignored while busy.
// Ports: clk_i/rst_n_i; load_* (buffer fill, idle only); start_i + size_*_in_i;
//        busy_o, ready_o, k_in_i_enable_o, k_in_k_enable_o, k_in_o (all registered).
module accelerator_read_keys_transmitter
    import accelerator_read_keys_transmitter_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int CONTROL_SIZE = CONTROL_SIZE_DEF,
    parameter int R_MAX        = R_MAX_DEF,
    parameter int W_MAX        = W_MAX_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   load_enable_i,
    input  logic [addr_width(R_MAX, W_MAX)-1:0]    load_addr_i,
    input  logic [DATA_SIZE-1:0]                   load_data_i,
    input  logic                                   start_i,
    input  logic [CONTROL_SIZE-1:0]                size_r_in_i,
    input  logic [CONTROL_SIZE-1:0]                size_w_in_i,
    output logic                                   busy_o,
    output logic                                   ready_o,
    output logic                                   k_in_i_enable_o,
    output logic                                   k_in_k_enable_o,
    output logic [DATA_SIZE-1:0]                   k_in_o
);

    localparam int AW  = addr_width(R_MAX, W_MAX);
    localparam int IW  = $clog2(R_MAX);
    localparam int KW  = $clog2(W_MAX);
    localparam int RCW = IW + 1;   // holds 0..R_MAX
    localparam int WCW = KW + 1;   // holds 0..W_MAX

    tx_state_t state_q, state_d;

    // i/k index the word shown on the outputs in the current cycle
    logic [IW-1:0]  i_q, i_d;
    logic [KW-1:0]  k_q, k_d;
    logic [RCW-1:0] r_q, r_d, r_sat;
    logic [WCW-1:0] w_q, w_d, w_sat;

    logic                 busy_q, ready_q, i_en_q, k_en_q;
    logic [DATA_SIZE-1:0] k_in_q;
    logic                 busy_d, ready_d, i_en_d, k_en_d;
    logic [DATA_SIZE-1:0] k_in_d;

    logic                 load_we;
    logic [AW-1:0]        rd_addr;
    logic [DATA_SIZE-1:0] rd_data;
    logic [DATA_SIZE-1:0] rd_word;
    logic                 last_k, last_i;

    // Full-width compare so large sizes with zero low bits still saturate
    assign r_sat = (size_r_in_i > CONTROL_SIZE'(R_MAX)) ? RCW'(R_MAX) : size_r_in_i[RCW-1:0];
    assign w_sat = (size_w_in_i > CONTROL_SIZE'(W_MAX)) ? WCW'(W_MAX) : size_w_in_i[WCW-1:0];

    assign last_k = ({1'b0, k_q} == (w_q - WCW'(1)));
    assign last_i = ({1'b0, i_q} == (r_q - RCW'(1)));

    // The buffer is frozen for the whole stream
    assign load_we = load_enable_i && (state_q == ST_IDLE);

    accelerator_read_keys_transmitter_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .AW        (AW)
    ) u_buffer (
        .clk_i   (clk_i),
        .we_i    (load_we),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        r_d     = r_q;
        w_d     = w_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    r_d     = r_sat;
                    w_d     = w_sat;
                    i_d     = '0;
                    k_d     = '0;
                    state_d = ((size_r_in_i == '0) || (size_w_in_i == '0)) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_k) begin
                    k_d = '0;
                    if (last_i) begin
                        i_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are precomputed for the next cycle from the next-state indices
        rd_addr = {i_d, k_d};
        // A load in the START cycle lands at the same edge as the first read, so forward it
        rd_word = (load_we && (load_addr_i == rd_addr)) ? load_data_i : rd_data;

        k_en_d  = (state_d == ST_STREAM);
        i_en_d  = k_en_d && (k_d == '0);
        k_in_d  = k_en_d ? rd_word : '0;
        ready_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            i_en_q  <= 1'b0;
            k_en_q  <= 1'b0;
            k_in_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            r_q     <= r_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            i_en_q  <= i_en_d;
            k_en_q  <= k_en_d;
            k_in_q  <= k_in_d;
        end
    end

    assign busy_o          = busy_q;
    assign ready_o         = ready_q;
    assign k_in_i_enable_o = i_en_q;
    assign k_in_k_enable_o = k_en_q;
    assign k_in_o          = k_in_q;

endmodule

// File: tb/tb_accelerator_read_keys_transmitter.sv
// Bench for accelerator_read_keys_transmitter: directed streams, scoreboard-checked output.
// Latency: stimulus and monitor both act on the falling edge, away from the active edge.
// Backpressure: none on the DUT side; expectations are queued ahead of each stream.
module tb_accelerator_read_keys_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [63:0] load_data;
    logic        start;
    logic [63:0] size_r, size_w;
    logic        busy, ready, i_en, k_en;
    logic [63:0] k_in;

    always #5 clk = ~clk;

    accelerator_read_keys_transmitter dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .load_enable_i   (load_en),
        .load_addr_i     (load_addr),
        .load_data_i     (load_data),
        .start_i         (start),
        .size_r_in_i     (size_r),
        .size_w_in_i     (size_w),
        .busy_o          (busy),
        .ready_o         (ready),
        .k_in_i_enable_o (i_en),
        .k_in_k_enable_o (k_en),
        .k_in_o          (k_in)
    );

    typedef struct {
        bit          is_ready;
        logic [63:0] dat;
        bit          ien;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mdl [64];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    // Monitor: every enable/READY cycle must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (k_en || ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_output", {62'd0, ready, k_en}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_ready) begin
                        chk(ready && !k_en, "ready_pulse", {62'd0, ready, k_en}, 64'd2);
                    end else begin
                        chk(k_en && !ready && (k_in === e.dat) && (i_en === e.ien),
                            "stream_word", {k_in[62:0], i_en}, {e.dat[62:0], e.ien});
                    end
                end
            end else begin
                chk((k_in === 64'd0) && (i_en === 1'b0), "idle_zero", {k_in[62:0], i_en}, 64'd0);
            end
        end
    end

    task automatic load_word(input int addr, input logic [63:0] data);
        load_en   = 1'b1;
        load_addr = 6'(addr);
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
        mdl[addr] = data;
    endtask

    task automatic check_outputs_zero(input string name);
        chk({busy, ready, i_en, k_en} === 4'b0000 && k_in === 64'd0, name,
            {k_in[59:0], busy, ready, i_en, k_en}, 64'd0);
    endtask

    // Queues the expected stream, issues START and measures READY latency.
    // inject: START + LOAD to addr 0 mid-stream (must be ignored).
    // co_load: load 0x5A5A to addr 0 in the START cycle (must be forwarded).
    task automatic run_stream(input logic [63:0] r, input logic [63:0] w,
                              input bit inject, input bit co_load, input string name);
        int   re, we_, n;
        exp_t e;
        re  = (r > 64'd4)  ? 4  : int'(r);
        we_ = (w > 64'd16) ? 16 : int'(w);
        if (re == 0 || we_ == 0) begin
            re  = 0;
            we_ = 0;
        end
        if (co_load) mdl[0] = 64'h5A5A;
        for (int i = 0; i < re; i++) begin
            for (int k = 0; k < we_; k++) begin
                e.is_ready = 1'b0;
                e.dat      = mdl[i*16+k];
                e.ien      = (k == 0);
                sb.push_back(e);
            end
        end
        e.is_ready = 1'b1;
        e.dat      = '0;
        e.ien      = 1'b0;
        sb.push_back(e);

        size_r = r;
        size_w = w;
        start  = 1'b1;
        if (co_load) begin
            load_en   = 1'b1;
            load_addr = 6'd0;
            load_data = 64'h5A5A;
        end
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        n = 1;
        chk(busy === 1'b1, {name, "_busy_first"}, {63'd0, busy}, 64'd1);
        while (!ready && n < 200) begin
            if (inject && n == 2) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_addr = 6'd0;
                load_data = 64'hDEAD;
            end else begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start   = 1'b0;
        load_en = 1'b0;
        chk(n == re*we_ + 1, {name, "_ready_latency"}, 64'(n), 64'(re*we_ + 1));
        @(negedge clk);
        chk(busy === 1'b0, {name, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        size_r    = '0;
        size_w    = '0;
        #1;
        check_outputs_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the buffer, with a reset pulse partway through configuration
        for (int a = 0; a < 64; a++) begin
            if (a == 20) begin
                #2 rst_n = 1'b0;
                #1 check_outputs_zero("reset_mid_config");
                @(negedge clk);
                rst_n = 1'b1;
            end
            load_word(a, 64'h100 * (a / 16) + 64'(a % 16));
        end

        run_stream(64'd2, 64'd3, 1'b0, 1'b0, "basic");
        run_stream(64'd9, 64'd40, 1'b0, 1'b0, "saturate");
        run_stream(64'h1_0000_0002, 64'd2, 1'b0, 1'b0, "wide_saturate");
        run_stream(64'd0, 64'd5, 1'b0, 1'b0, "zero_r");
        run_stream(64'd3, 64'd0, 1'b0, 1'b0, "zero_w");
        run_stream(64'd2, 64'd3, 1'b1, 1'b0, "ignored_inputs");
        run_stream(64'd1, 64'd1, 1'b0, 1'b0, "single_word");

        // Reset after the third word of a 2x3 stream
        begin
            exp_t e;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 3; k++) begin
                    e.is_ready = 1'b0;
                    e.dat      = mdl[i*16+k];
                    e.ien      = (k == 0);
                    sb.push_back(e);
                end
            end
            e.is_ready = 1'b1;
            e.dat      = '0;
            e.ien      = 1'b0;
            sb.push_back(e);
            size_r = 64'd2;
            size_w = 64'd3;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1 check_outputs_zero("reset_mid_stream");
            chk(sb.size() == 4, "words_before_reset", 64'(sb.size()), 64'd4);
            sb.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(negedge clk);
        end
        run_stream(64'd2, 64'd3, 1'b0, 1'b0, "replay_after_reset");

        run_stream(64'd1, 64'd2, 1'b0, 1'b1, "load_with_start");

        repeat (3) @(negedge clk);
        chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
